// File: rtl/elevator_scan_ctrl_if.sv
// Request/status bundle of the SCAN elevator controller.
// master: request source and status observer; slave: the controller.
interface elevator_scan_ctrl_if #(
  parameter int unsigned NUM_FLOORS = 10
);
  localparam int unsigned FLOOR_BITS = $clog2(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] upreq;
  logic [NUM_FLOORS-1:0] downreq;
  logic [NUM_FLOORS-1:0] carreq;
  logic [FLOOR_BITS-1:0] floor;
  logic                  up_move;
  logic                  down_move;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic [6:0]            A;

  modport master (
    output upreq, downreq, carreq,
    input  floor, up_move, down_move, door_open, pending, A
  );

  modport slave (
    input  upreq, downreq, carreq,
    output floor, up_move, down_move, door_open, pending, A
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller: latched hall/cabin calls, SCAN scheduling,
// per-floor travel timer, timed door and 7-segment floor display.
// Optional macro ELEVATOR_ESTOP_EN adds an estop input that freezes motion.
// Outputs are registered images of the control state, one cycle behind it.
// 7-segment encoding: A[0]=a .. A[6]=g, active high.
module elevator_scan_ctrl #(
  parameter int unsigned NUM_FLOORS    = 10,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic clk,
  input  logic resetN,
`ifdef ELEVATOR_ESTOP_EN
  input  logic estop,
`endif
  elevator_scan_ctrl_if.slave bus
);

  localparam int unsigned FLOOR_BITS = $clog2(NUM_FLOORS);
  localparam int unsigned CNT_MAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_BITS-1:0] TOP_FLOOR   = FLOOR_BITS'(NUM_FLOORS - 1);
  // Top floor has no up call, ground floor has no down call.
  localparam logic [NUM_FLOORS-1:0] UP_MASK     = ~(NUM_FLOORS'(1) << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_MASK     = ~NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [FLOOR_BITS-1:0] floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] up_q, up_d;
  logic [NUM_FLOORS-1:0] dn_q, dn_d;
  logic [NUM_FLOORS-1:0] car_q, car_d;

  logic [FLOOR_BITS-1:0] floor_out_q;
  logic                  up_move_q;
  logic                  down_move_q;
  logic                  door_open_q;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [6:0]            seg_q;

  logic [NUM_FLOORS-1:0] pend;
  logic [NUM_FLOORS-1:0] up_set, dn_set, car_set;
  logic [NUM_FLOORS-1:0] cur_mask, door_mask, keep_mask;
  logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic                  enter_door;
  logic                  served;
  logic                  frozen;

`ifdef ELEVATOR_ESTOP_EN
  assign frozen = estop;
`else
  assign frozen = 1'b0;
`endif

  assign pend    = up_q | dn_q | car_q;
  assign up_set  = bus.upreq & UP_MASK;
  assign dn_set  = bus.downreq & DN_MASK;
  assign car_set = bus.carreq;

  // Any request strictly beyond floor f in the given direction.
  function automatic logic ahead(input logic [NUM_FLOORS-1:0] v,
                                 input logic [FLOOR_BITS-1:0] f,
                                 input logic                  up);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (v[i] && (up ? (FLOOR_BITS'(i) > f) : (FLOOR_BITS'(i) < f))) r = 1'b1;
    end
    return r;
  endfunction

  // Stop test applied on arrival at a new floor.
  function automatic logic stop_here(input logic [FLOOR_BITS-1:0] f,
                                     input logic                  up,
                                     input logic [NUM_FLOORS-1:0] v_car,
                                     input logic [NUM_FLOORS-1:0] v_up,
                                     input logic [NUM_FLOORS-1:0] v_dn);
    logic [NUM_FLOORS-1:0] v_all;
    v_all = v_car | v_up | v_dn;
    return (f == '0) || (f == TOP_FLOOR) || v_car[f] ||
           (up ? v_up[f] : v_dn[f]) || (v_all[f] && !ahead(v_all, f, up));
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Control state, floor, direction, timer and request latches.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      car_q    <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      car_q    <= car_d;
    end
  end

  // SCAN scheduling, timers, request serving and latch update.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    cnt_d      = cnt_q;
    enter_door = 1'b0;
    served     = 1'b0;
    clr_up     = '0;
    clr_dn     = '0;
    clr_car    = '0;
    cur_mask   = NUM_FLOORS'(1) << floor_q;
    door_mask  = '0;
    keep_mask  = '1;
    up_d       = up_q;
    dn_d       = dn_q;
    car_d      = car_q;

    if (!frozen) begin
      case (state_q)
        IDLE: begin
          if (pend[floor_q]) begin
            enter_door = 1'b1;
          end else if (ahead(pend, floor_q, 1'b1)) begin
            state_d  = MOVE_UP;
            dir_up_d = 1'b1;
            cnt_d    = TRAVEL_LOAD;
          end else if (ahead(pend, floor_q, 1'b0)) begin
            state_d  = MOVE_DOWN;
            dir_up_d = 1'b0;
            cnt_d    = TRAVEL_LOAD;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (cnt_q == '0) begin
            floor_d = (state_q == MOVE_UP) ? floor_q + FLOOR_BITS'(1)
                                           : floor_q - FLOOR_BITS'(1);
            if (stop_here(floor_d, dir_up_q, car_q, up_q, dn_q)) enter_door = 1'b1;
            else                                                  cnt_d = TRAVEL_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DOOR_OPEN: begin
          if (|((up_set | dn_set | car_set) & cur_mask)) begin
            served = 1'b1;
            cnt_d  = DOOR_LOAD;
          end else if (cnt_q == '0) begin
            if (ahead(pend, floor_q, dir_up_q)) begin
              state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
              cnt_d   = TRAVEL_LOAD;
            end else if (ahead(pend, floor_q, !dir_up_q)) begin
              state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
              dir_up_d = !dir_up_q;
              cnt_d    = TRAVEL_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // Door opening: serve the floor in the travel direction; reverse at the end of a sweep.
      if (enter_door) begin
        state_d   = DOOR_OPEN;
        cnt_d     = DOOR_LOAD;
        door_mask = NUM_FLOORS'(1) << floor_d;
        clr_car   = door_mask;
        if (dir_up_q) clr_up = door_mask;
        else          clr_dn = door_mask;
        if (!ahead(pend, floor_d, dir_up_q)) begin
          clr_up   = door_mask;
          clr_dn   = door_mask;
          dir_up_d = !dir_up_q;
        end
      end
    end

    if (served) keep_mask = ~cur_mask;
    up_d  = (up_q  & ~clr_up)  | (up_set  & keep_mask);
    dn_d  = (dn_q  & ~clr_dn)  | (dn_set  & keep_mask);
    car_d = (car_q & ~clr_car) | (car_set & keep_mask);
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      floor_out_q <= '0;
      up_move_q   <= 1'b0;
      down_move_q <= 1'b0;
      door_open_q <= 1'b0;
      pending_q   <= '0;
      seg_q       <= seg7(4'd0);
    end else begin
      floor_out_q <= floor_q;
      up_move_q   <= !frozen && (state_q == MOVE_UP);
      down_move_q <= !frozen && (state_q == MOVE_DOWN);
      door_open_q <= !frozen && (state_q == DOOR_OPEN);
      pending_q   <= pend;
      seg_q       <= seg7(4'(floor_q));
    end
  end

  assign bus.floor     = floor_out_q;
  assign bus.up_move   = up_move_q;
  assign bus.down_move = down_move_q;
  assign bus.door_open = door_open_q;
  assign bus.pending   = pending_q;
  assign bus.A         = seg_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios plus random calls,
// every cycle compared against a request-list model of the SCAN rules.
module tb_elevator_scan_ctrl;
  localparam int unsigned N  = 10;
  localparam int unsigned T  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned FB = $clog2(N);

  localparam int PH_IDLE = 0;
  localparam int PH_UP   = 1;
  localparam int PH_DN   = 2;
  localparam int PH_DOOR = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic es = 1'b0;

  elevator_scan_ctrl_if #(.NUM_FLOORS(N)) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)
  ) dut (
    .clk(clk),
    .resetN(resetN),
`ifdef ELEVATOR_ESTOP_EN
    .estop(es),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int checks = 0;
  int failures = 0;

  // Model: where the car is, what it is doing, cycles left in that activity, open calls.
  int         m_floor;
  bit         m_dir_up;
  int         m_ph;
  int         m_left;
  logic [N-1:0] m_up, m_dn, m_car;

  // Expected outputs after the current edge.
  int         e_floor;
  bit         e_up, e_dn, e_door;
  logic [N-1:0] e_pend;
  logic [6:0] e_seg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ahead(input logic [N-1:0] p, input int f, input bit up);
    for (int i = 0; i < int'(N); i++)
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic open_door();
    m_ph   = PH_DOOR;
    m_left = D;
    m_car[m_floor] = 1'b0;
    if (m_dir_up) m_up[m_floor] = 1'b0;
    else          m_dn[m_floor] = 1'b0;
    if (!ahead(m_car | m_up | m_dn, m_floor, m_dir_up)) begin
      m_up[m_floor] = 1'b0;
      m_dn[m_floor] = 1'b0;
      m_dir_up = !m_dir_up;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] u, d, c, p;
    bit served;
    u = bus.upreq;   u[N-1] = 1'b0;
    d = bus.downreq; d[0]   = 1'b0;
    c = bus.carreq;
    if (!resetN) begin
      m_floor = 0; m_dir_up = 1'b1; m_ph = PH_IDLE; m_left = 0;
      m_up = '0; m_dn = '0; m_car = '0;
      e_floor = 0; e_up = 0; e_dn = 0; e_door = 0; e_pend = '0; e_seg = SEG[0];
      return;
    end
    p = m_car | m_up | m_dn;
    e_floor = m_floor;
    e_up    = !es && (m_ph == PH_UP);
    e_dn    = !es && (m_ph == PH_DN);
    e_door  = !es && (m_ph == PH_DOOR);
    e_pend  = p;
    e_seg   = SEG[m_floor];
    if (es) begin
      m_up |= u; m_dn |= d; m_car |= c;
      return;
    end
    served = (m_ph == PH_DOOR) && (u[m_floor] || d[m_floor] || c[m_floor]);
    case (m_ph)
      PH_IDLE: begin
        if (p[m_floor])                    open_door();
        else if (ahead(p, m_floor, 1'b1)) begin m_dir_up = 1'b1; m_ph = PH_UP; m_left = T; end
        else if (ahead(p, m_floor, 1'b0)) begin m_dir_up = 1'b0; m_ph = PH_DN; m_left = T; end
      end
      PH_UP, PH_DN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_ph == PH_UP) ? 1 : -1;
          if (m_floor == 0 || m_floor == int'(N) - 1 || m_car[m_floor] ||
              (m_dir_up ? m_up[m_floor] : m_dn[m_floor]) ||
              (p[m_floor] && !ahead(p, m_floor, m_dir_up)))
            open_door();
          else
            m_left = T;
        end
      end
      default: begin
        if (served) m_left = D;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (ahead(p, m_floor, m_dir_up)) begin
              m_ph = m_dir_up ? PH_UP : PH_DN; m_left = T;
            end else if (ahead(p, m_floor, !m_dir_up)) begin
              m_dir_up = !m_dir_up; m_ph = m_dir_up ? PH_UP : PH_DN; m_left = T;
            end else begin
              m_ph = PH_IDLE;
            end
          end
        end
      end
    endcase
    if (served) begin u[m_floor] = 1'b0; d[m_floor] = 1'b0; c[m_floor] = 1'b0; end
    m_up |= u; m_dn |= d; m_car |= c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("floor",     32'(bus.floor),     32'(e_floor));
    chk("up_move",   32'(bus.up_move),   32'(e_up));
    chk("down_move", 32'(bus.down_move), 32'(e_dn));
    chk("door_open", 32'(bus.door_open), 32'(e_door));
    chk("pending",   32'(bus.pending),   32'(e_pend));
    chk("A",         32'(bus.A),         32'(e_seg));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic req(input logic [N-1:0] u, input logic [N-1:0] d, input logic [N-1:0] c);
    bus.upreq = u; bus.downreq = d; bus.carreq = c;
    tick();
    bus.upreq = '0; bus.downreq = '0; bus.carreq = '0;
  endtask

  function automatic logic [N-1:0] bitn(input int i);
    return N'(1) << i;
  endfunction

  initial begin
    logic [N-1:0] ru, rd, rc;
    bus.upreq = '0; bus.downreq = '0; bus.carreq = '0;
    resetN = 1'b0;
    idle(2);
    chk("rst_A", 32'(bus.A), 32'h3F);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    resetN = 1'b1;

    // Call at the current floor while idle: door two edges later, open for D cycles.
    req('0, '0, bitn(0));
    tick();
    chk("s1_door_early", 32'(bus.door_open), 32'h0);
    tick();
    chk("s1_door_open", 32'(bus.door_open), 32'h1);
    idle(12);
    chk("s1_door_closed", 32'(bus.door_open), 32'h0);
    chk("s1_pending", 32'(bus.pending), 32'h0);

    // Three-floor trip up.
    req('0, '0, bitn(3));
    idle(20);
    chk("s2_floor", 32'(bus.floor), 32'd3);
    chk("s2_A", 32'(bus.A), 32'h4F);
    chk("s2_door", 32'(bus.door_open), 32'h1);
    idle(20);

    // Hall calls picked up in sweep order, reversal at the top of the sweep.
    resetN = 1'b0; tick(); resetN = 1'b1;
    req('0, '0, bitn(5));
    idle(12);
    req(bitn(4), bitn(2), '0);
    idle(80);
    chk("s3_floor", 32'(bus.floor), 32'd2);
    chk("s3_pending", 32'(bus.pending), 32'h0);

    // Tie between above and below from idle: up first.
    req('0, '0, bitn(4));
    idle(40);
    chk("s4_start", 32'(bus.floor), 32'd4);
    req(bitn(7), '0, bitn(1));
    idle(4);
    chk("s4_up_first", 32'(bus.up_move), 32'h1);
    idle(100);
    chk("s4_floor", 32'(bus.floor), 32'd1);

    // Cabin call at the open floor holds the door instead of latching.
    req('0, '0, bitn(3));
    idle(14);
    req('0, '0, bitn(3));
    idle(7);
    chk("s5_door_held", 32'(bus.door_open), 32'h1);
    chk("s5_pending", 32'(bus.pending), 32'h0);
    idle(3);
    chk("s5_door_closed", 32'(bus.door_open), 32'h0);

`ifdef ELEVATOR_ESTOP_EN
    // Emergency stop mid-travel.
    req('0, '0, bitn(6));
    idle(6);
    es = 1'b1;
    idle(5);
    chk("s6_frozen", 32'(bus.up_move), 32'h0);
    es = 1'b0;
    idle(40);
`endif

    // Random calls, occasional reset (and estop when present).
    for (int k = 0; k < 4000; k++) begin
      ru = '0; rd = '0; rc = '0;
      if ($urandom_range(0, 11) == 0) ru[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 11) == 0) rd[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 7) == 0)  rc[$urandom_range(0, N - 1)] = 1'b1;
      resetN = ($urandom_range(0, 799) != 0);
`ifdef ELEVATOR_ESTOP_EN
      if ($urandom_range(0, 59) == 0) es = !es;
`endif
      req(ru, rd, rc);
    end
    resetN = 1'b1;
    es = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
